// File: rtl/fault_input_monitor.sv
// Multi-channel fault/status pin supervisor: two-FF sync, programmable deglitch,
// sticky edge-latched status with power-up blanking and a masked registered irq.
module fault_input_monitor #(
    parameter int unsigned             CHANNELS          = 4,
    parameter int unsigned             COUNTER_WIDTH     = 8,
    parameter int unsigned             DEFAULT_THRESHOLD = 16,
    parameter logic [CHANNELS-1:0]     INACTIVE_LEVEL    = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CHANNELS-1:0]      in,
    input  logic [COUNTER_WIDTH-1:0] cfg_threshold,
    input  logic                     cfg_load,
    input  logic [CHANNELS-1:0]      mask,
    input  logic [CHANNELS-1:0]      clear,
    output logic [CHANNELS-1:0]      level,
    output logic [CHANNELS-1:0]      status,
    output logic                     irq
);

    localparam int unsigned CW = COUNTER_WIDTH;
    localparam int unsigned BW = COUNTER_WIDTH + 2;

    localparam logic [CW-1:0] ONE_CW = CW'(1);
    localparam logic [CW:0]   ONE_CE = (CW + 1)'(1);
    localparam logic [BW-1:0] ONE_B  = BW'(1);
    localparam logic [BW-1:0] TWO_B  = BW'(2);

    typedef enum logic {
        ST_BLANK,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       blank_cnt_q, blank_cnt_d;
    logic [CW-1:0]       thr_q, thr_d;
    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] prev_active_q, prev_active_d;
    logic [CHANNELS-1:0] status_q, status_d;
    logic                irq_q, irq_d;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];

    logic [CW-1:0]       teff;
    logic [BW-1:0]       blank_target;
    logic                go_run;
    logic [CHANNELS-1:0] active_q, active_d, rise, set_v;

    assign teff         = (thr_q == '0) ? ONE_CW : thr_q;
    assign blank_target = {2'b00, teff} + TWO_B;

    // Synchroniser and per-channel stability filter
    always_comb begin
        sync1_d = in;
        sync_d  = sync1_q;
        thr_d   = cfg_load ? cfg_threshold : thr_q;
        level_d = level_q;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            if (cfg_load) begin
                cnt_d[i] = '0;
            end else if (sync_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (({1'b0, cnt_q[i]} + ONE_CE) >= {1'b0, teff}) begin
                level_d[i] = sync_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + ONE_CW;
            end
        end
    end

    // Blanking state machine
    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        go_run      = 1'b0;
        unique case (state_q)
            ST_BLANK: begin
                if (cfg_load) begin
                    blank_cnt_d = '0;
                end else if ((blank_cnt_q + ONE_B) >= blank_target) begin
                    state_d = ST_RUN;
                    go_run  = 1'b1;
                end else begin
                    blank_cnt_d = blank_cnt_q + ONE_B;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Status latching and interrupt
    always_comb begin
        active_q = level_q ^ INACTIVE_LEVEL;
        active_d = level_d ^ INACTIVE_LEVEL;
        rise     = active_q & ~prev_active_q;
        set_v    = '0;
        if (state_q == ST_RUN) begin
            set_v = rise;
        end else if (go_run) begin
            set_v = active_d;
        end
        // On leaving BLANK the post-edge level is already reported, so seed the
        // edge detector with it to avoid a second set on the following edge.
        prev_active_d = go_run ? active_d : active_q;
        status_d      = (status_q & ~clear) | set_v;
        irq_d         = |(status_q & mask);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BLANK;
            blank_cnt_q   <= '0;
            thr_q         <= CW'(DEFAULT_THRESHOLD);
            sync1_q       <= INACTIVE_LEVEL;
            sync_q        <= INACTIVE_LEVEL;
            level_q       <= INACTIVE_LEVEL;
            prev_active_q <= '0;
            status_q      <= '0;
            irq_q         <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            blank_cnt_q   <= blank_cnt_d;
            thr_q         <= thr_d;
            sync1_q       <= sync1_d;
            sync_q        <= sync_d;
            level_q       <= level_d;
            prev_active_q <= prev_active_d;
            status_q      <= status_d;
            irq_q         <= irq_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level  = level_q;
    assign status = status_q;
    assign irq    = irq_q;

endmodule

// File: doc/fault_input_monitor.md
# fault_input_monitor

Multi-channel supervisor for asynchronous fault and status pins (gate-driver nFAULT, overcurrent comparators, limit switches). Each channel is synchronised, deglitched with one runtime-programmable stability threshold, and edge-detected into a sticky status bit. A masked, registered interrupt is raised toward the CPU. It replaces the per-pin fixed-threshold filter instances and adds configuration, power-up blanking and event latching.

## Interface
- CHANNELS, 4, number of monitored inputs
- COUNTER_WIDTH, 8, width of the threshold and per-channel stability counters
- DEFAULT_THRESHOLD, 16, active threshold after reset
- INACTIVE_LEVEL, '0 (CHANNELS bits), per-channel idle logic level; the opposite level is "active"

Ports:
- clk  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- in  in  CHANNELS  raw asynchronous pins
- cfg_threshold  in  COUNTER_WIDTH  new threshold value
- cfg_load  in  1  one-cycle pulse; loads cfg_threshold
- mask  in  CHANNELS  1 = channel may drive irq
- clear  in  CHANNELS  write-one-to-clear pulse for status
- level  out  CHANNELS  filtered level per channel (raw polarity)
- status  out  CHANNELS  sticky "became active" flags
- irq  out  1  registered OR of status & mask

## Operation
- Reset values: sync FFs and level = INACTIVE_LEVEL; counters 0; status 0; irq 0; active threshold = DEFAULT_THRESHOLD; state BLANK with blank counter 0.
- Teff = max(active threshold, 1).
- Sync: two FFs per channel; the filter uses only the second stage (sync).
- Filter, per channel, each edge:
  - If sync == level: counter <= 0.
  - Else if counter + 1 >= Teff: level <= sync, counter <= 0.
  - Else counter <= counter + 1.
  - Symmetric: both assertion and release need Teff stable cycles. The counter never wraps.
- cfg_load: active threshold <= cfg_threshold. All channel counters clear on the same edge and take priority over the filter update. level is unchanged.
- State machine:
  - BLANK: the blank counter increments each cycle. Status setting is suppressed. When the count reaches Teff + 2, go to RUN. At that transition, every channel whose level is active gets status set, so faults present at power-up are not lost. cfg_load in BLANK restarts the blank counter at 0.
  - RUN: terminal until reset.
- Status (RUN only): set on the edge after level goes inactive -> active (registered edge detect). An active -> inactive transition does not touch status.
- Clear: clear[i] = 1 clears status[i]. If a set and a clear for the same channel occur on the same edge, set wins.
- irq <= |(status & mask), registered. Masking hides a channel from irq but does not stop it latching status.
- Async reset mid-operation returns every register to its reset value immediately, including re-entering BLANK.

## Timing
- A pin change sampled at edge k reaches sync at edge k+1.
  - If the level differs, level flips at edge k+1+Teff.
  - status sets at edge k+2+Teff.
  - irq asserts at edge k+3+Teff.
- Glitch suppression: a pulse shorter than Teff cycles at sync never changes level. A pulse of exactly Teff cycles does.
- cfg_load at edge j: the new Teff governs counting from edge j+1. Counting restarts from 0.
- clear at edge j: status low after j. irq falls at j+1 if no other masked status bit remains set.
- BLANK length: Teff + 2 cycles after reset deassertion, or after the last cfg_load during BLANK.

## Test plan
- Reset, DEFAULT_THRESHOLD = 16, INACTIVE_LEVEL = 0, all inputs low -> RUN after 18 cycles; level = 0, status = 0, irq = 0.
- Threshold 4 loaded, ch0 driven high at edge k:
  - level[0] rises at k+5, status[0] at k+6, irq at k+7 with mask = 1.
  - A 3-cycle pulse on ch1 leaves level[1] and status[1] at 0.
- ch2 held active through reset -> status[2] sets on the BLANK -> RUN transition; irq follows one cycle later.
- clear[0] on the same edge a new ch0 rising filtered edge occurs -> status[0] stays 1. A later lone clear[0] drops status[0], and irq drops the next cycle.
- mask = 0 with ch3 fault -> status[3] = 1, irq stays 0. Setting mask[3] = 1 raises irq next cycle.
- cfg_load of 0 mid-count (counter at 10, old threshold 16) -> counter clears; level follows sync after 1 stable cycle (Teff = 1). Asserting reset mid-count -> all outputs 0 immediately and BLANK restarts.
